control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit for the single-bus CPU; the sequencer end of the DataPath control interface.
- Generates every per-cycle DataPath strobe (register select, bus-drive, latch, memory, ALU opcode) from the instruction register.
- Runs fetch, decode and execute steps T0–T7 for each instruction.
- Sits beside DataPath: receives IR, drives all control inputs, and replaces the hand-written stimulus used in phase-2 benches.

Parameters:
- FETCH_STEPS, 3, number of fetch steps (T0–T2); fixed, not for override.
- OPW, 5, opcode and ALU-op width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents. Fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0]. Field decode happens in DataPath.
- stop  in  1  request to halt at the next instruction boundary.
- run  out  1  1 while executing; 0 in HALT and during reset.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select and control.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin  out  1 each.
- Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout, R8_RAin  out  1 each.
- Read, Write  out  1 each  memory strobes.
- opcode  out  5  ALU operation; 5'b0 unless Zin is asserted.

Behaviour:
- State register: {HALT, T0..T7}.
- Reset: while clear=0, state=T0, run=0, all strobes 0, opcode=0. Reset mid-instruction abandons it; the first rising edge after clear rises executes T0.
- Outputs are Moore-decoded from (state, IR op). Each strobe is high for the entire cycle of its step and low in every other step.
- Fetch (all ops):
  - T0: PCout, MARin, IncPC.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- Execute begins at T3 with the op latched in IR at the end of T2. The last step of each op returns to T0. If stop=1 at that return, go to HALT instead.
- ALU codes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, jr 10100, jal 10101, mfhi 11000, mflo 11001, nop 11010, halt 11011.
- Execute sequences:
  - R-type (add..shl): T3 Grb,Rout,Yin. T4 Grc,Rout,Zin,opcode=op. T5 Zlowout,Gra,Rin.
  - neg/not: T3 Grb,Rout,Zin,opcode=op. T4 Zlowout,Gra,Rin.
  - mul/div: T3 Gra,Rout,Yin. T4 Grb,Rout,Zin,opcode=op. T5 Zlowout,LOin. T6 Zhighout,HIin.
  - addi/andi/ori: T3 Grb,Rout,Yin. T4 Cout,Zin, opcode=add/and/or respectively. T5 Zlowout,Gra,Rin.
  - ldi: T3 Grb,BAout,Yin. T4 Cout,Zin,opcode=00011. T5 Zlowout,Gra,Rin.
  - ld: same T3–T4 as ldi. T5 Zlowout,MARin. T6 Read,MDRin. T7 MDRout,Gra,Rin.
  - st: T3–T5 as ld. T6 Gra,Rout,MDRin (Read=0). T7 Write.
  - jr: T3 Gra,Rout,PCin.
  - jal: T3 PCout,R8_RAin. T4 Gra,Rout,PCin.
  - mfhi: T3 HIout,Gra,Rin. mflo: T3 LOout,Gra,Rin.
  - nop and undefined ops: T3 no strobes, then return.
  - halt: T3 → HALT.
- HALT: all strobes 0, run=0. Exit only via clear.
- stop is level-sampled only at instruction completion; assertion mid-instruction does not shorten it.
- Invariants: never more than one bus driver per cycle; Read and Write never both 1.

Decomposition:
- Package cpu_ctrl_pkg holds: opcode localparams (above), step/state encoding, and field bit positions.
- One sub-module, ctrl_decode: purely combinational (state, op) → strobe vector.
- control_sequencer keeps the state register, step advance, stop/halt logic, and reset gating.

Test Plan:
- Reset then IR=0x18918000 (add R1,R2,R3): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,opcode=00011; T5 Zlowout,Gra,Rin; next cycle T0 with PCout,MARin,IncPC.
- IR=0xAA800000 (jal R5): T3 PCout,R8_RAin; T4 Gra,Rout,PCin; 5 cycles total from T0.
- IR=0x00900010 (ld R1,0x10(R2)): T4 Cout,Zin,opcode=00011; T6 Read,MDRin; T7 MDRout,Gra,Rin; Write=0 throughout.
- IR=0xD8000000 (halt): after T3, run=0 and all strobes stay 0 for 20 cycles; clear low→high restarts at T0 with run=1.
- stop raised during T4 of a mul: T5 LOin and T6 HIin still occur, then HALT. Plus an assertion check over every state that bus drivers are one-hot-or-zero.
- clear pulsed low during T5 of st: outputs go 0 asynchronously, Write never asserted, fetch restarts at T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_pkg                                                         |
// | Opcodes, step encoding, IR field positions and strobe bundle for the |
// | hardwired control sequencer.                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_ctrl_pkg;

   localparam int FETCH_STEPS = 3;
   localparam int OPW         = 5;

   localparam int c_OP_MSB = 31;
   localparam int c_OP_LSB = 27;
   localparam int c_RA_MSB = 26;
   localparam int c_RA_LSB = 23;
   localparam int c_RB_MSB = 22;
   localparam int c_RB_LSB = 19;
   localparam int c_RC_MSB = 18;
   localparam int c_RC_LSB = 15;
   localparam int c_C_MSB  = 18;
   localparam int c_C_LSB  = 0;

   localparam int c_ST_W = 4;
   localparam logic [c_ST_W-1:0] c_ST_T0   = 4'd0;
   localparam logic [c_ST_W-1:0] c_ST_T1   = 4'd1;
   localparam logic [c_ST_W-1:0] c_ST_T2   = 4'd2;
   localparam logic [c_ST_W-1:0] c_ST_T3   = 4'(FETCH_STEPS);
   localparam logic [c_ST_W-1:0] c_ST_T4   = 4'd4;
   localparam logic [c_ST_W-1:0] c_ST_T5   = 4'd5;
   localparam logic [c_ST_W-1:0] c_ST_T6   = 4'd6;
   localparam logic [c_ST_W-1:0] c_ST_T7   = 4'd7;
   localparam logic [c_ST_W-1:0] c_ST_HALT = 4'd8;

   localparam logic [OPW-1:0] c_OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] c_OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] c_OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] c_OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] c_OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] c_OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] c_OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] c_OP_ROR  = 5'b00111;
   localparam logic [OPW-1:0] c_OP_ROL  = 5'b01000;
   localparam logic [OPW-1:0] c_OP_SHR  = 5'b01001;
   localparam logic [OPW-1:0] c_OP_SHRA = 5'b01010;
   localparam logic [OPW-1:0] c_OP_SHL  = 5'b01011;
   localparam logic [OPW-1:0] c_OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] c_OP_ANDI = 5'b01101;
   localparam logic [OPW-1:0] c_OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] c_OP_DIV  = 5'b01111;
   localparam logic [OPW-1:0] c_OP_MUL  = 5'b10000;
   localparam logic [OPW-1:0] c_OP_NEG  = 5'b10001;
   localparam logic [OPW-1:0] c_OP_NOT  = 5'b10010;
   localparam logic [OPW-1:0] c_OP_JR   = 5'b10100;
   localparam logic [OPW-1:0] c_OP_JAL  = 5'b10101;
   localparam logic [OPW-1:0] c_OP_MFHI = 5'b11000;
   localparam logic [OPW-1:0] c_OP_MFLO = 5'b11001;
   localparam logic [OPW-1:0] c_OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] c_OP_HALT = 5'b11011;

   typedef struct packed {
      logic           Gra;
      logic           Grb;
      logic           Grc;
      logic           Rin;
      logic           Rout;
      logic           BAout;
      logic           PCout;
      logic           PCin;
      logic           IncPC;
      logic           MARin;
      logic           MDRin;
      logic           MDRout;
      logic           IRin;
      logic           Yin;
      logic           Zin;
      logic           Zlowout;
      logic           Zhighout;
      logic           HIin;
      logic           HIout;
      logic           LOin;
      logic           LOout;
      logic           Cout;
      logic           R8_RAin;
      logic           Read;
      logic           Write;
      logic [OPW-1:0] alu_op;
   } strobes_t;

   localparam int c_STROBE_W = $bits(strobes_t);

   // Final execute step of each op; everything not listed finishes in T3.
   function automatic logic [c_ST_W-1:0] last_step(input logic [OPW-1:0] op);
      case (op)
         c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_ROR, c_OP_ROL,
         c_OP_SHR, c_OP_SHRA, c_OP_SHL, c_OP_ADDI, c_OP_ANDI, c_OP_ORI,
         c_OP_LDI:                     last_step = c_ST_T5;
         c_OP_NEG, c_OP_NOT, c_OP_JAL: last_step = c_ST_T4;
         c_OP_MUL, c_OP_DIV:           last_step = c_ST_T6;
         c_OP_LD, c_OP_ST:             last_step = c_ST_T7;
         default:                      last_step = c_ST_T3;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_decode                                                          |
// | Combinational (step, opcode) to DataPath strobe decode.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [c_ST_W-1:0]     state,
   input  logic [OPW-1:0]        op,
   output logic [c_STROBE_W-1:0] strobes
);

   strobes_t w_s;

   always_comb begin
      w_s = '0;
      case (state)
         c_ST_T0: begin w_s.PCout = 1'b1; w_s.MARin = 1'b1; w_s.IncPC = 1'b1; end
         c_ST_T1: begin w_s.Read = 1'b1; w_s.MDRin = 1'b1; end
         c_ST_T2: begin w_s.MDRout = 1'b1; w_s.IRin = 1'b1; end
         c_ST_T3, c_ST_T4, c_ST_T5, c_ST_T6, c_ST_T7: begin
            case (op)
               c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_ROR, c_OP_ROL,
               c_OP_SHR, c_OP_SHRA, c_OP_SHL: begin
                  case (state)
                     c_ST_T3: begin w_s.Grb = 1'b1; w_s.Rout = 1'b1; w_s.Yin = 1'b1; end
                     c_ST_T4: begin w_s.Grc = 1'b1; w_s.Rout = 1'b1; w_s.Zin = 1'b1; w_s.alu_op = op; end
                     c_ST_T5: begin w_s.Zlowout = 1'b1; w_s.Gra = 1'b1; w_s.Rin = 1'b1; end
                     default: ;
                  endcase
               end
               c_OP_NEG, c_OP_NOT: begin
                  case (state)
                     c_ST_T3: begin w_s.Grb = 1'b1; w_s.Rout = 1'b1; w_s.Zin = 1'b1; w_s.alu_op = op; end
                     c_ST_T4: begin w_s.Zlowout = 1'b1; w_s.Gra = 1'b1; w_s.Rin = 1'b1; end
                     default: ;
                  endcase
               end
               c_OP_MUL, c_OP_DIV: begin
                  case (state)
                     c_ST_T3: begin w_s.Gra = 1'b1; w_s.Rout = 1'b1; w_s.Yin = 1'b1; end
                     c_ST_T4: begin w_s.Grb = 1'b1; w_s.Rout = 1'b1; w_s.Zin = 1'b1; w_s.alu_op = op; end
                     c_ST_T5: begin w_s.Zlowout = 1'b1; w_s.LOin = 1'b1; end
                     c_ST_T6: begin w_s.Zhighout = 1'b1; w_s.HIin = 1'b1; end
                     default: ;
                  endcase
               end
               c_OP_ADDI, c_OP_ANDI, c_OP_ORI: begin
                  case (state)
                     c_ST_T3: begin w_s.Grb = 1'b1; w_s.Rout = 1'b1; w_s.Yin = 1'b1; end
                     c_ST_T4: begin
                        w_s.Cout   = 1'b1;
                        w_s.Zin    = 1'b1;
                        w_s.alu_op = (op == c_OP_ADDI) ? c_OP_ADD :
                                     (op == c_OP_ANDI) ? c_OP_AND : c_OP_OR;
                     end
                     c_ST_T5: begin w_s.Zlowout = 1'b1; w_s.Gra = 1'b1; w_s.Rin = 1'b1; end
                     default: ;
                  endcase
               end
               // Memory ops share the effective-address computation of ldi.
               c_OP_LDI, c_OP_LD, c_OP_ST: begin
                  case (state)
                     c_ST_T3: begin w_s.Grb = 1'b1; w_s.BAout = 1'b1; w_s.Yin = 1'b1; end
                     c_ST_T4: begin w_s.Cout = 1'b1; w_s.Zin = 1'b1; w_s.alu_op = c_OP_ADD; end
                     c_ST_T5: begin
                        w_s.Zlowout = 1'b1;
                        if (op == c_OP_LDI) begin
                           w_s.Gra = 1'b1;
                           w_s.Rin = 1'b1;
                        end else begin
                           w_s.MARin = 1'b1;
                        end
                     end
                     c_ST_T6: begin
                        w_s.MDRin = 1'b1;
                        if (op == c_OP_LD) begin
                           w_s.Read = 1'b1;
                        end else if (op == c_OP_ST) begin
                           w_s.Gra  = 1'b1;
                           w_s.Rout = 1'b1;
                        end
                     end
                     c_ST_T7: begin
                        if (op == c_OP_LD) begin
                           w_s.MDRout = 1'b1;
                           w_s.Gra    = 1'b1;
                           w_s.Rin    = 1'b1;
                        end else if (op == c_OP_ST) begin
                           w_s.Write = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
               c_OP_JR: begin
                  if (state == c_ST_T3) begin
                     w_s.Gra = 1'b1; w_s.Rout = 1'b1; w_s.PCin = 1'b1;
                  end
               end
               c_OP_JAL: begin
                  case (state)
                     c_ST_T3: begin w_s.PCout = 1'b1; w_s.R8_RAin = 1'b1; end
                     c_ST_T4: begin w_s.Gra = 1'b1; w_s.Rout = 1'b1; w_s.PCin = 1'b1; end
                     default: ;
                  endcase
               end
               c_OP_MFHI: begin
                  if (state == c_ST_T3) begin
                     w_s.HIout = 1'b1; w_s.Gra = 1'b1; w_s.Rin = 1'b1;
                  end
               end
               c_OP_MFLO: begin
                  if (state == c_ST_T3) begin
                     w_s.LOout = 1'b1; w_s.Gra = 1'b1; w_s.Rin = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign strobes = w_s;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer                                                    |
// | Hardwired T0-T7 step sequencer driving the single-bus DataPath.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic           clock,
   input  logic           clear,
   input  logic [31:0]    IR,
   input  logic           stop,
   output logic           run,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           Rin,
   output logic           Rout,
   output logic           BAout,
   output logic           PCout,
   output logic           PCin,
   output logic           IncPC,
   output logic           MARin,
   output logic           MDRin,
   output logic           MDRout,
   output logic           IRin,
   output logic           Yin,
   output logic           Zin,
   output logic           Zlowout,
   output logic           Zhighout,
   output logic           HIin,
   output logic           HIout,
   output logic           LOin,
   output logic           LOout,
   output logic           Cout,
   output logic           R8_RAin,
   output logic           Read,
   output logic           Write,
   output logic [OPW-1:0] opcode
);

   logic [c_ST_W-1:0]     r_state;
   logic [c_ST_W-1:0]     w_state_next;
   logic [OPW-1:0]        w_op;
   logic [c_STROBE_W-1:0] w_dec_vec;
   strobes_t              w_dec;
   strobes_t              w_out;
   logic                  w_unused_ir;

   assign w_op        = IR[c_OP_MSB:c_OP_LSB];
   assign w_unused_ir = ^IR[c_RA_MSB:c_C_LSB];

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= c_ST_T0;
      end else begin
         r_state <= w_state_next;
      end
   end

   // stop is only honoured on the final step of an instruction.
   always_comb begin
      w_state_next = c_ST_T0;
      case (r_state)
         c_ST_HALT: w_state_next = c_ST_HALT;
         c_ST_T0:   w_state_next = c_ST_T1;
         c_ST_T1:   w_state_next = c_ST_T2;
         c_ST_T2:   w_state_next = c_ST_T3;
         c_ST_T3, c_ST_T4, c_ST_T5, c_ST_T6, c_ST_T7: begin
            if (w_op == c_OP_HALT) begin
               w_state_next = c_ST_HALT;
            end else if (r_state == last_step(w_op)) begin
               w_state_next = stop ? c_ST_HALT : c_ST_T0;
            end else begin
               w_state_next = r_state + 4'd1;
            end
         end
         default:   w_state_next = c_ST_T0;
      endcase
   end

   ctrl_decode u_decode (
      .state   (r_state),
      .op      (w_op),
      .strobes (w_dec_vec)
   );

   assign w_dec = strobes_t'(w_dec_vec);

   // Strobes are forced low for as long as clear is held, not just at the edge.
   always_comb begin
      w_out = w_dec;
      if (!clear) begin
         w_out = '0;
      end
   end

   assign run      = clear && (r_state != c_ST_HALT);
   assign Gra      = w_out.Gra;
   assign Grb      = w_out.Grb;
   assign Grc      = w_out.Grc;
   assign Rin      = w_out.Rin;
   assign Rout     = w_out.Rout;
   assign BAout    = w_out.BAout;
   assign PCout    = w_out.PCout;
   assign PCin     = w_out.PCin;
   assign IncPC    = w_out.IncPC;
   assign MARin    = w_out.MARin;
   assign MDRin    = w_out.MDRin;
   assign MDRout   = w_out.MDRout;
   assign IRin     = w_out.IRin;
   assign Yin      = w_out.Yin;
   assign Zin      = w_out.Zin;
   assign Zlowout  = w_out.Zlowout;
   assign Zhighout = w_out.Zhighout;
   assign HIin     = w_out.HIin;
   assign HIout    = w_out.HIout;
   assign LOin     = w_out.LOin;
   assign LOout    = w_out.LOout;
   assign Cout     = w_out.Cout;
   assign R8_RAin  = w_out.R8_RAin;
   assign Read     = w_out.Read;
   assign Write    = w_out.Write;
   assign opcode   = w_out.alu_op;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_sequencer                                                 |
// | Directed self-checking bench for the control sequencer.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] IR;
   logic        stop;
   logic        run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
   logic        MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout;
   logic        LOin, LOout, Cout, R8_RAin, Read, Write;
   logic [4:0]  opcode;
   int          n_tests;
   int          n_fail;

   localparam logic [24:0] S_GRA = 25'd1 << 24, S_GRB = 25'd1 << 23, S_GRC = 25'd1 << 22;
   localparam logic [24:0] S_RIN = 25'd1 << 21, S_ROUT = 25'd1 << 20, S_BAOUT = 25'd1 << 19;
   localparam logic [24:0] S_PCOUT = 25'd1 << 18, S_PCIN = 25'd1 << 17, S_INCPC = 25'd1 << 16;
   localparam logic [24:0] S_MARIN = 25'd1 << 15, S_MDRIN = 25'd1 << 14, S_MDROUT = 25'd1 << 13;
   localparam logic [24:0] S_IRIN = 25'd1 << 12, S_YIN = 25'd1 << 11, S_ZIN = 25'd1 << 10;
   localparam logic [24:0] S_ZLO = 25'd1 << 9, S_ZHI = 25'd1 << 8, S_HIIN = 25'd1 << 7;
   localparam logic [24:0] S_HIOUT = 25'd1 << 6, S_LOIN = 25'd1 << 5, S_LOOUT = 25'd1 << 4;
   localparam logic [24:0] S_COUT = 25'd1 << 3, S_R8 = 25'd1 << 2, S_READ = 25'd1 << 1;
   localparam logic [24:0] S_WRITE = 25'd1;
   localparam logic [24:0] F0 = S_PCOUT | S_MARIN | S_INCPC;
   localparam logic [24:0] F1 = S_READ | S_MDRIN;
   localparam logic [24:0] F2 = S_MDROUT | S_IRIN;

   wire [30:0] obs = {run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin,
                      MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout,
                      LOin, LOout, Cout, R8_RAin, Read, Write, opcode};

   control_sequencer dut (
      .clock(clock), .clear(clear), .IR(IR), .stop(stop), .run(run),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
      .Zhighout(Zhighout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
      .Cout(Cout), .R8_RAin(R8_RAin), .Read(Read), .Write(Write), .opcode(opcode)
   );

   always #5 clock = ~clock;

   function automatic logic [30:0] e(input logic r, input logic [24:0] s, input logic [4:0] op);
      return {r, s, op};
   endfunction

   // Every cycle: at most one bus driver, never Read and Write together.
   always @(negedge clock) begin
      #2;
      n_tests++;
      if ($countones({Rout, BAout, PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Cout}) > 1) begin
         n_fail++;
         $display("FAIL bus_onehot t=%0t: drivers=%b required at most one", $time,
                  {Rout, BAout, PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Cout});
      end
      n_tests++;
      if (Read && Write) begin
         n_fail++;
         $display("FAIL read_write t=%0t: Read=%b Write=%b required not both", $time, Read, Write);
      end
   end

   task automatic do_reset(input logic [31:0] ir_val);
      IR    = ir_val;
      clear = 1'b0;
      @(negedge clock);
      clear = 1'b1;
   endtask

   task automatic test_reset;
      clear = 1'b0;
      IR    = 32'h18918000;
      repeat (3) @(negedge clock);
      #1;
      n_tests++;
      if (obs !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h required %h", obs, 31'd0);
      end
      @(negedge clock);
      #1;
      n_tests++;
      if (obs !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_hold2: got %h required %h", obs, 31'd0);
      end
   endtask

   task automatic test_add;
      logic [30:0] exp [7];
      exp = '{e(1, F0, 0), e(1, F1, 0), e(1, F2, 0), e(1, S_GRB | S_ROUT | S_YIN, 0),
              e(1, S_GRC | S_ROUT | S_ZIN, 5'b00011), e(1, S_ZLO | S_GRA | S_RIN, 0),
              e(1, F0, 0)};
      do_reset(32'h18918000);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL add step %0d: got %h required %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_jal;
      logic [30:0] exp [6];
      exp = '{e(1, F0, 0), e(1, F1, 0), e(1, F2, 0), e(1, S_PCOUT | S_R8, 0),
              e(1, S_GRA | S_ROUT | S_PCIN, 0), e(1, F0, 0)};
      do_reset(32'hAA800000);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL jal step %0d: got %h required %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_ld;
      logic [30:0] exp [9];
      exp = '{e(1, F0, 0), e(1, F1, 0), e(1, F2, 0), e(1, S_GRB | S_BAOUT | S_YIN, 0),
              e(1, S_COUT | S_ZIN, 5'b00011), e(1, S_ZLO | S_MARIN, 0),
              e(1, S_READ | S_MDRIN, 0), e(1, S_MDROUT | S_GRA | S_RIN, 0), e(1, F0, 0)};
      do_reset(32'h00900010);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL ld step %0d: got %h required %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_neg;
      logic [30:0] exp [6];
      exp = '{e(1, F0, 0), e(1, F1, 0), e(1, F2, 0),
              e(1, S_GRB | S_ROUT | S_ZIN, 5'b10001), e(1, S_ZLO | S_GRA | S_RIN, 0),
              e(1, F0, 0)};
      do_reset(32'h88900000);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL neg step %0d: got %h required %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_undef;
      logic [30:0] exp [5];
      exp = '{e(1, F0, 0), e(1, F1, 0), e(1, F2, 0), e(1, 25'd0, 0), e(1, F0, 0)};
      do_reset(32'h98000000);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL undef step %0d: got %h required %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_halt;
      logic [30:0] exp [4];
      logic [30:0] want;
      exp = '{e(1, F0, 0), e(1, F1, 0), e(1, F2, 0), e(1, 25'd0, 0)};
      do_reset(32'hD8000000);
      for (int i = 0; i < 24; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         want = (i < 4) ? exp[i] : 31'd0;
         n_tests++;
         if (obs !== want) begin
            n_fail++;
            $display("FAIL halt step %0d: got %h required %h", i, obs, want);
         end
      end
      clear = 1'b0;
      #1;
      n_tests++;
      if (obs !== 31'd0) begin
         n_fail++;
         $display("FAIL halt_clear: got %h required %h", obs, 31'd0);
      end
      @(negedge clock);
      clear = 1'b1;
      #1;
      n_tests++;
      if (obs !== e(1, F0, 0)) begin
         n_fail++;
         $display("FAIL halt_restart_t0: got %h required %h", obs, e(1, F0, 0));
      end
      @(negedge clock);
      #1;
      n_tests++;
      if (obs !== e(1, F1, 0)) begin
         n_fail++;
         $display("FAIL halt_restart_t1: got %h required %h", obs, e(1, F1, 0));
      end
   endtask

   task automatic test_stop_mul;
      logic [30:0] exp [10];
      exp = '{e(1, F0, 0), e(1, F1, 0), e(1, F2, 0), e(1, S_GRA | S_ROUT | S_YIN, 0),
              e(1, S_GRB | S_ROUT | S_ZIN, 5'b10000), e(1, S_ZLO | S_LOIN, 0),
              e(1, S_ZHI | S_HIIN, 0), e(0, 25'd0, 0), e(0, 25'd0, 0), e(0, 25'd0, 0)};
      do_reset(32'h80980000);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL stop_mul step %0d: got %h required %h", i, obs, exp[i]);
         end
         if (i == 4) stop = 1'b1;
      end
      stop = 1'b0;
   endtask

   task automatic test_clear_mid_st;
      logic [30:0] exp [6];
      exp = '{e(1, F0, 0), e(1, F1, 0), e(1, F2, 0), e(1, S_GRB | S_BAOUT | S_YIN, 0),
              e(1, S_COUT | S_ZIN, 5'b00011), e(1, S_ZLO | S_MARIN, 0)};
      do_reset(32'h10900010);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL st_abort step %0d: got %h required %h", i, obs, exp[i]);
         end
      end
      clear = 1'b0;
      #1;
      n_tests++;
      if (obs !== 31'd0) begin
         n_fail++;
         $display("FAIL st_async_clear: got %h required %h", obs, 31'd0);
      end
      @(negedge clock);
      #1;
      n_tests++;
      if (obs !== 31'd0) begin
         n_fail++;
         $display("FAIL st_clear_held: got %h required %h", obs, 31'd0);
      end
      clear = 1'b1;
      #1;
      n_tests++;
      if (obs !== e(1, F0, 0)) begin
         n_fail++;
         $display("FAIL st_restart_t0: got %h required %h", obs, e(1, F0, 0));
      end
      @(negedge clock);
      #1;
      n_tests++;
      if (obs !== e(1, F1, 0)) begin
         n_fail++;
         $display("FAIL st_restart_t1: got %h required %h", obs, e(1, F1, 0));
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clear   = 1'b0;
      stop    = 1'b0;
      IR      = 32'd0;
      test_reset;
      test_add;
      test_jal;
      test_ld;
      test_neg;
      test_undef;
      test_halt;
      test_stop_mul;
      test_clear_mid_st;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
